// File: rtl/seven_seg_scan_n_if.sv
// Datapath-side bundle for the N-digit seven-segment scanner.
// The master drives the nibbles, decimal points, brightness and enable.
interface seven_seg_scan_n_if #(
    parameter int N_DIGITS = 4
);
    logic                  en_i;
    logic [4*N_DIGITS-1:0] bcd_i;
    logic [N_DIGITS-1:0]   dp_i;
    logic [2:0]            bright_i;

    modport master (
        output en_i,
        output bcd_i,
        output dp_i,
        output bright_i
    );

    modport slave (
        input en_i,
        input bcd_i,
        input dp_i,
        input bright_i
    );
endinterface

// File: rtl/seven_seg_scan_n.sv
// N-digit time-multiplexed 7-segment driver with frame latching,
// leading-zero/anti-ghost blanking, brightness and optional hex glyphs.
module seven_seg_scan_n #(
    parameter int N_DIGITS        = 4,
    parameter int DISPLAY_REFRESH = 27000,
    parameter int BLANK_CYCLES    = 64,
    parameter int HEX_MODE        = 0,
    parameter int BLANK_LEADING   = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    seven_seg_scan_n_if.slave   disp,
    output logic [N_DIGITS-1:0] anodo_o,
    output logic [6:0]          catodo_o,
    output logic                dp_o,
    output logic                frame_o
);

    localparam int CNT_W    = $clog2(DISPLAY_REFRESH);
    localparam int IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int DIM_STEP = DISPLAY_REFRESH / 8;

    logic [CNT_W-1:0]      elapsed;
    logic [IDX_W-1:0]      idx;
    logic [4*N_DIGITS-1:0] shadow_bcd;
    logic [N_DIGITS-1:0]   shadow_dp;

    logic                  slot_end;
    logic                  last_idx;
    logic                  frame_start;
    logic [CNT_W:0]        lit_end;
    logic                  lit;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_zero;
    logic                  cur_blank;
    logic [N_DIGITS:0]     zero_hi;
    logic [N_DIGITS-1:0]   anode_sel;

    function automatic logic [6:0] glyph(input logic [3:0] nib);
        logic [6:0] seg;
        unique case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    assign slot_end    = (elapsed == CNT_W'(DISPLAY_REFRESH - 1));
    assign last_idx    = (idx == IDX_W'(N_DIGITS - 1));
    assign frame_start = (elapsed == '0) && (idx == '0);

    // Lit window closes at a brightness-scaled fraction of the slot.
    assign lit_end = ((CNT_W+1)'(disp.bright_i) + (CNT_W+1)'(1))
                   * (CNT_W+1)'(DIM_STEP);
    assign lit = ({1'b0, elapsed} >= (CNT_W+1)'(BLANK_CYCLES))
              && ({1'b0, elapsed} < lit_end);

    assign anode_sel = {{(N_DIGITS-1){1'b0}}, 1'b1} << idx;

    // zero_hi[k] is set when digit k and every digit above it are zero.
    always_comb begin
        zero_hi           = '0;
        zero_hi[N_DIGITS] = 1'b1;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            zero_hi[k] = zero_hi[k+1] && (shadow_bcd[4*k +: 4] == 4'h0);
        end
    end

    always_comb begin
        cur_nib  = 4'h0;
        cur_dp   = 1'b0;
        cur_zero = 1'b0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_nib  = shadow_bcd[4*k +: 4];
                cur_dp   = shadow_dp[k];
                cur_zero = zero_hi[k] && (k != 0);
            end
        end
        cur_blank = ((BLANK_LEADING != 0) && cur_zero)
                 || ((HEX_MODE == 0) && (cur_nib > 4'd9));
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            elapsed    <= '0;
            idx        <= '0;
            shadow_bcd <= '0;
            shadow_dp  <= '0;
        end else if (!disp.en_i) begin
            elapsed <= '0;
            idx     <= '0;
        end else begin
            if (frame_start) begin
                shadow_bcd <= disp.bcd_i;
                shadow_dp  <= disp.dp_i;
            end
            if (slot_end) begin
                elapsed <= '0;
                idx     <= last_idx ? '0 : idx + IDX_W'(1);
            end else begin
                elapsed <= elapsed + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i || !disp.en_i) begin
            anodo_o  <= '1;
            catodo_o <= 7'h7F;
            dp_o     <= 1'b1;
            frame_o  <= 1'b0;
        end else begin
            anodo_o  <= lit ? ~anode_sel : '1;
            catodo_o <= (lit && !cur_blank) ? glyph(cur_nib) : 7'h7F;
            dp_o     <= ~(lit && cur_dp);
            frame_o  <= frame_start;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_n.sv
// Randomised and directed bench for seven_seg_scan_n, two instances
// (hex+leading-blank, decimal+no-blank) against a time-based model.
module tb_seven_seg_scan_n;

    localparam int N   = 4;
    localparam int REF = 16;
    localparam int BLK = 2;
    localparam int FRM = N * REF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seven_seg_scan_n_if #(.N_DIGITS(N)) bus ();

    logic [3:0] an_a, an_b;
    logic [6:0] cat_a, cat_b;
    logic       dpo_a, dpo_b, fr_a, fr_b;

    seven_seg_scan_n #(
        .N_DIGITS(N), .DISPLAY_REFRESH(REF), .BLANK_CYCLES(BLK),
        .HEX_MODE(1), .BLANK_LEADING(1)
    ) u_dut (
        .clk_i(clk), .rst_i(rst_n), .disp(bus),
        .anodo_o(an_a), .catodo_o(cat_a), .dp_o(dpo_a), .frame_o(fr_a)
    );

    seven_seg_scan_n #(
        .N_DIGITS(N), .DISPLAY_REFRESH(REF), .BLANK_CYCLES(BLK),
        .HEX_MODE(0), .BLANK_LEADING(0)
    ) u_dut_dec (
        .clk_i(clk), .rst_i(rst_n), .disp(bus),
        .anodo_o(an_b), .catodo_o(cat_b), .dp_o(dpo_b), .frame_o(fr_b)
    );

    int vectors = 0;
    int errors  = 0;

    int          phase;
    logic [15:0] sh_bcd;
    logic [3:0]  sh_dp;
    logic [12:0] exp_a, exp_b;
    logic [6:0]  glyph_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Expected {anodes, segments, dp, frame} after the next edge.
    function automatic logic [12:0] predict(bit hex, bit lead);
        int         el = phase % REF;
        int         ix = (phase / REF) % N;
        logic [3:0] nib;
        bit         lit, blank;
        nib   = sh_bcd[ix*4 +: 4];
        lit   = (el >= BLK) && (el < (int'(bus.bright_i) + 1) * (REF / 8));
        blank = (!hex && nib > 4'd9)
             || (lead && ix > 0 && (sh_bcd >> (4 * ix)) == 16'h0);
        return {lit ? ~(4'b0001 << ix) : 4'hF,
                (lit && !blank) ? glyph_tab[nib] : 7'h7F,
                ~(lit && sh_dp[ix]),
                phase % FRM == 0};
    endfunction

    task automatic tick();
        if (!rst_n) begin
            exp_a  = {4'hF, 7'h7F, 1'b1, 1'b0};
            exp_b  = exp_a;
            phase  = 0;
            sh_bcd = '0;
            sh_dp  = '0;
        end else if (!bus.en_i) begin
            exp_a = {4'hF, 7'h7F, 1'b1, 1'b0};
            exp_b = exp_a;
            phase = 0;
        end else begin
            exp_a = predict(1'b1, 1'b1);
            exp_b = predict(1'b0, 1'b0);
            if (phase % FRM == 0) begin
                sh_bcd = bus.bcd_i;
                sh_dp  = bus.dp_i;
            end
            phase++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.en_i = 1'b1;
        bus.bcd_i = 16'h1234;
        bus.dp_i = 4'h0;
        bus.bright_i = 3'd7;
        for (int c = 0; c < 5; c++) begin
            tick();
            vectors++;
            if ({an_a, cat_a, dpo_a, fr_a} !== 13'h1FFE) begin
                errors++;
                $display("FAIL reset_hold got %h want 1ffe",
                         {an_a, cat_a, dpo_a, fr_a});
            end
        end
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) tick();
        rst_n = 1'b0;
        tick();
        vectors++;
        if ({an_a, cat_a, dpo_a, fr_a} !== 13'h1FFE) begin
            errors++;
            $display("FAIL reset_mid got %h want 1ffe",
                     {an_a, cat_a, dpo_a, fr_a});
        end
        rst_n = 1'b1;
        tick();
        vectors++;
        if (fr_a !== 1'b1) begin
            errors++;
            $display("FAIL reset_restart_frame got %b want 1", fr_a);
        end
        for (int c = 0; c < 70; c++) begin
            tick();
            vectors += 2;
            if ({an_a, cat_a, dpo_a, fr_a} !== exp_a) begin
                errors++;
                $display("FAIL reset_run_a ph=%0d got %h want %h",
                         phase, {an_a, cat_a, dpo_a, fr_a}, exp_a);
            end
            if ({an_b, cat_b, dpo_b, fr_b} !== exp_b) begin
                errors++;
                $display("FAIL reset_run_b ph=%0d got %h want %h",
                         phase, {an_b, cat_b, dpo_b, fr_b}, exp_b);
            end
        end
    endtask

    task automatic test_scan();
        int lit0 = 0;
        int frames = 0;
        bus.bcd_i = 16'h1234;
        bus.dp_i = 4'h0;
        bus.bright_i = 3'd7;
        for (int c = 0; c < 2 * FRM; c++) begin
            tick();
            if (c >= FRM && an_a == 4'hE) lit0++;
            if (fr_a) frames++;
            vectors += 2;
            if ({an_a, cat_a, dpo_a, fr_a} !== exp_a) begin
                errors++;
                $display("FAIL scan_a ph=%0d got %h want %h",
                         phase, {an_a, cat_a, dpo_a, fr_a}, exp_a);
            end
            if ({an_b, cat_b, dpo_b, fr_b} !== exp_b) begin
                errors++;
                $display("FAIL scan_b ph=%0d got %h want %h",
                         phase, {an_b, cat_b, dpo_b, fr_b}, exp_b);
            end
        end
        vectors += 2;
        if (lit0 != 14) begin
            errors++;
            $display("FAIL scan_digit0_lit got %0d want 14", lit0);
        end
        if (frames != 2) begin
            errors++;
            $display("FAIL scan_frame_pulses got %0d want 2", frames);
        end
    endtask

    task automatic test_leading_zero();
        logic [15:0] pats [2] = '{16'h0070, 16'h0000};
        int          want [2] = '{28, 14};
        int          shown;
        for (int p = 0; p < 2; p++) begin
            bus.bcd_i = pats[p];
            shown = 0;
            for (int c = 0; c < 2 * FRM; c++) begin
                tick();
                if (c >= FRM && cat_a != 7'h7F) shown++;
                vectors++;
                if ({an_a, cat_a, dpo_a, fr_a} !== exp_a) begin
                    errors++;
                    $display("FAIL lead_a ph=%0d got %h want %h",
                             phase, {an_a, cat_a, dpo_a, fr_a}, exp_a);
                end
            end
            vectors++;
            if (shown != want[p]) begin
                errors++;
                $display("FAIL lead_count pat=%h got %0d want %0d",
                         pats[p], shown, want[p]);
            end
        end
    endtask

    task automatic test_tearing();
        int guard = 0;
        bit seen = 1'b0;
        bus.bcd_i = 16'h1234;
        for (int c = 0; c < FRM; c++) tick();
        while (phase % FRM != 2 * REF + 5 && guard < 2 * FRM) begin
            tick();
            guard++;
        end
        vectors++;
        if (guard >= 2 * FRM) begin
            errors++;
            $display("FAIL tear_align got ph=%0d want %0d", phase, 37);
        end
        bus.bcd_i = 16'h5678;
        for (int c = 0; c < 2 * FRM; c++) begin
            tick();
            if (!seen && an_a == 4'h7) begin
                seen = 1'b1;
                vectors++;
                if (cat_a !== 7'h79) begin
                    errors++;
                    $display("FAIL tear_old_digit3 got %h want 79", cat_a);
                end
            end
            vectors += 2;
            if ({an_a, cat_a, dpo_a, fr_a} !== exp_a) begin
                errors++;
                $display("FAIL tear_a ph=%0d got %h want %h",
                         phase, {an_a, cat_a, dpo_a, fr_a}, exp_a);
            end
            if ({an_b, cat_b, dpo_b, fr_b} !== exp_b) begin
                errors++;
                $display("FAIL tear_b ph=%0d got %h want %h",
                         phase, {an_b, cat_b, dpo_b, fr_b}, exp_b);
            end
        end
    endtask

    task automatic test_brightness();
        logic [2:0] lv [2] = '{3'd3, 3'd0};
        int         want [2] = '{24, 0};
        int         lit_n;
        for (int p = 0; p < 2; p++) begin
            bus.bright_i = lv[p];
            lit_n = 0;
            for (int c = 0; c < FRM; c++) begin
                tick();
                if (an_a != 4'hF) lit_n++;
                vectors++;
                if ({an_a, cat_a, dpo_a, fr_a} !== exp_a) begin
                    errors++;
                    $display("FAIL bright_a ph=%0d got %h want %h",
                             phase, {an_a, cat_a, dpo_a, fr_a}, exp_a);
                end
            end
            vectors++;
            if (lit_n != want[p]) begin
                errors++;
                $display("FAIL bright_count lvl=%0d got %0d want %0d",
                         lv[p], lit_n, want[p]);
            end
        end
        bus.bright_i = 3'd7;
    endtask

    task automatic test_hex_dp();
        int dp_on = 0;
        int dec_on = 0;
        bus.bcd_i = 16'hABCF;
        bus.dp_i = 4'b0010;
        bus.bright_i = 3'd7;
        for (int c = 0; c < 2 * FRM; c++) begin
            tick();
            if (c >= FRM && dpo_a == 1'b0) dp_on++;
            if (c >= FRM && cat_b != 7'h7F) dec_on++;
            vectors += 2;
            if ({an_a, cat_a, dpo_a, fr_a} !== exp_a) begin
                errors++;
                $display("FAIL hex_a ph=%0d got %h want %h",
                         phase, {an_a, cat_a, dpo_a, fr_a}, exp_a);
            end
            if ({an_b, cat_b, dpo_b, fr_b} !== exp_b) begin
                errors++;
                $display("FAIL hex_b ph=%0d got %h want %h",
                         phase, {an_b, cat_b, dpo_b, fr_b}, exp_b);
            end
        end
        vectors += 2;
        if (dp_on != 14) begin
            errors++;
            $display("FAIL hex_dp_count got %0d want 14", dp_on);
        end
        if (dec_on != 0) begin
            errors++;
            $display("FAIL dec_blank_count got %0d want 0", dec_on);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 19) == 0) begin
                for (int k = 0; k < N; k++)
                    bus.bcd_i[4*k +: 4] = ($urandom_range(0, 2) == 0)
                        ? 4'h0 : 4'($urandom);
                bus.dp_i = 4'($urandom);
            end
            if ($urandom_range(0, 9) == 0)
                bus.bright_i = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 59) == 0)
                bus.en_i = ~bus.en_i;
            else if (!bus.en_i && $urandom_range(0, 7) == 0)
                bus.en_i = 1'b1;
            rst_n = ($urandom_range(0, 299) != 0);
            tick();
            vectors += 2;
            if ({an_a, cat_a, dpo_a, fr_a} !== exp_a) begin
                errors++;
                $display("FAIL rand_a ph=%0d got %h want %h",
                         phase, {an_a, cat_a, dpo_a, fr_a}, exp_a);
            end
            if ({an_b, cat_b, dpo_b, fr_b} !== exp_b) begin
                errors++;
                $display("FAIL rand_b ph=%0d got %h want %h",
                         phase, {an_b, cat_b, dpo_b, fr_b}, exp_b);
            end
        end
        rst_n = 1'b1;
        bus.en_i = 1'b1;
    endtask

    task automatic test_enable();
        bus.bcd_i = 16'h0905;
        bus.dp_i = 4'b0001;
        for (int c = 0; c < FRM + 20; c++) tick();
        bus.bcd_i = 16'h1111;
        bus.en_i = 1'b0;
        for (int c = 0; c < 7; c++) begin
            tick();
            vectors++;
            if ({an_a, cat_a, dpo_a, fr_a} !== 13'h1FFE) begin
                errors++;
                $display("FAIL enable_dark got %h want 1ffe",
                         {an_a, cat_a, dpo_a, fr_a});
            end
        end
        bus.en_i = 1'b1;
        for (int c = 0; c < FRM + 4; c++) begin
            tick();
            vectors++;
            if ({an_a, cat_a, dpo_a, fr_a} !== exp_a) begin
                errors++;
                $display("FAIL enable_a ph=%0d got %h want %h",
                         phase, {an_a, cat_a, dpo_a, fr_a}, exp_a);
            end
        end
    endtask

    initial begin
        phase  = 0;
        sh_bcd = '0;
        sh_dp  = '0;
        test_reset();
        test_scan();
        test_leading_zero();
        test_tearing();
        test_brightness();
        test_hex_dp();
        test_enable();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
